// File: rtl/crack_pkg.sv
// Shared types and constants for the hash-cracking engine.
// State encoding, LED codes and default parameter values.
package crack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DICT    = 3'd2,
    ST_BRUTE   = 3'd3,
    ST_SUCCESS = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam logic [2:0] LED_IDLE = 3'b011;
  localparam logic [2:0] LED_BUSY = 3'b100;
  localparam logic [2:0] LED_OK   = 3'b010;
  localparam logic [2:0] LED_FAIL = 3'b001;

  localparam int DEF_HASH_W         = 128;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DICT_START     = 1;
  localparam int DEF_DICT_SIZE      = 3;
  localparam int DEF_BRUTE_ATTEMPTS = 10;

  function automatic logic [2:0] led_code(input state_e s);
    logic [2:0] r;
    r = LED_IDLE;
    case (s)
      ST_LOAD,
      ST_DICT,
      ST_BRUTE:   r = LED_BUSY;
      ST_SUCCESS: r = LED_OK;
      ST_FAIL:    r = LED_FAIL;
      default:    r = LED_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crack_brute_gen.sv
// Brute-force candidate counter: yields 0..ATTEMPTS-1, zero-extended.
// Held at zero while clr_i is high; last_o flags the final candidate.
module crack_brute_gen
  import crack_pkg::*;
#(
  parameter int HASH_W   = DEF_HASH_W,
  parameter int ATTEMPTS = DEF_BRUTE_ATTEMPTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [HASH_W-1:0] cand_o,
  output logic              last_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cand_o = HASH_W'(cnt_q);
  assign last_o = (cnt_q == 32'(ATTEMPTS - 1));

endmodule

// File: rtl/crack_engine.sv
// Dictionary + optional brute-force hash cracker (BRUTE phase built
// only when CRACK_BRUTE_EN is defined; otherwise exhaustion -> FAIL).
module crack_engine
  import crack_pkg::*;
#(
  parameter int HASH_W         = DEF_HASH_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DICT_START     = DEF_DICT_START,
  parameter int DICT_SIZE      = DEF_DICT_SIZE,
  parameter int BRUTE_ATTEMPTS = DEF_BRUTE_ATTEMPTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [HASH_W-1:0] mem_rdata,
  output logic              hash_req,
  output logic [HASH_W-1:0] hash_cand,
  input  logic              hash_ack,
  input  logic [HASH_W-1:0] hash_out,
  output logic [2:0]        state,
  output logic [2:0]        led,
  output logic              found,
  output logic [HASH_W-1:0] found_word,
  output logic [31:0]       attempts
);

  if (longint'(DICT_START) + longint'(DICT_SIZE)
      > (longint'(1) << ADDR_W)) begin : g_bad_dict
    $error("crack_engine: dictionary exceeds address space");
  end
  if (DICT_SIZE < 0 || BRUTE_ATTEMPTS < 0) begin : g_bad_cnt
    $error("crack_engine: negative size parameter");
  end

  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(DICT_START);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(DICT_SIZE - 1);

`ifdef CRACK_BRUTE_EN
  localparam state_e ST_EXH =
    (BRUTE_ATTEMPTS > 0) ? ST_BRUTE : ST_FAIL;
`else
  localparam state_e ST_EXH = ST_FAIL;
`endif

  state_e            st_q, st_d;
  logic              start_q;
  logic              rd_vld_q;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [HASH_W-1:0] tgt_q, tgt_d;
  logic [HASH_W-1:0] cand_q, cand_d;
  logic              req_q, req_d;
  logic              fnd_q, fnd_d;
  logic [HASH_W-1:0] fw_q, fw_d;
  logic [31:0]       att_q, att_d;

  logic start_rise;
  logic acc;
  logic hit;

  assign start_rise = start & ~start_q;
  // A hash_ack only counts while a request is outstanding.
  assign acc = req_q & hash_ack;
  assign hit = acc && (hash_out == tgt_q);

`ifdef CRACK_BRUTE_EN
  logic              br_adv;
  logic              br_last;
  logic [HASH_W-1:0] br_cand;

  crack_brute_gen #(
    .HASH_W  (HASH_W),
    .ATTEMPTS(BRUTE_ATTEMPTS)
  ) u_brute (
    .clk   (clk),
    .reset (reset),
    .clr_i (st_q != ST_BRUTE),
    .adv_i (br_adv),
    .cand_o(br_cand),
    .last_o(br_last)
  );
`endif

  always_comb begin
    st_d     = st_q;
    mem_en_d = 1'b0;
    addr_d   = addr_q;
    idx_d    = idx_q;
    tgt_d    = tgt_q;
    cand_d   = cand_q;
    req_d    = req_q;
    fnd_d    = fnd_q;
    fw_d     = fw_q;
    att_d    = att_q;
`ifdef CRACK_BRUTE_EN
    br_adv   = 1'b0;
`endif
    if (acc && att_q != '1) begin
      att_d = att_q + 32'd1;
    end
    case (st_q)
      ST_IDLE: begin
        if (start_rise && !hash_ack) begin
          mem_en_d = 1'b1;
          addr_d   = '0;
          st_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rd_vld_q) begin
          tgt_d = mem_rdata;
          idx_d = '0;
          if (DICT_SIZE > 0) begin
            mem_en_d = 1'b1;
            addr_d   = A_START;
            st_d     = ST_DICT;
          end else begin
            st_d = ST_EXH;
          end
        end
      end
      ST_DICT: begin
        if (rd_vld_q) begin
          cand_d = mem_rdata;
          req_d  = 1'b1;
        end
        if (acc) begin
          req_d = 1'b0;
          if (hit) begin
            fnd_d = 1'b1;
            fw_d  = cand_q;
            st_d  = ST_SUCCESS;
          end else if (idx_q == A_LAST) begin
            st_d = ST_EXH;
          end else begin
            idx_d    = idx_q + 1'b1;
            mem_en_d = 1'b1;
            addr_d   = A_START + idx_q + 1'b1;
          end
        end
      end
`ifdef CRACK_BRUTE_EN
      ST_BRUTE: begin
        // Idle cycle between requests loads the next candidate.
        if (!req_q) begin
          cand_d = br_cand;
          req_d  = 1'b1;
        end else if (acc) begin
          req_d = 1'b0;
          if (hit) begin
            fnd_d = 1'b1;
            fw_d  = cand_q;
            st_d  = ST_SUCCESS;
          end else if (br_last) begin
            st_d = ST_FAIL;
          end else begin
            br_adv = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      start_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      mem_en_q <= 1'b0;
      addr_q   <= '0;
      idx_q    <= '0;
      tgt_q    <= '0;
      cand_q   <= '0;
      req_q    <= 1'b0;
      fnd_q    <= 1'b0;
      fw_q     <= '0;
      att_q    <= '0;
    end else begin
      st_q     <= st_d;
      start_q  <= start;
      rd_vld_q <= mem_en_q;
      mem_en_q <= mem_en_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      tgt_q    <= tgt_d;
      cand_q   <= cand_d;
      req_q    <= req_d;
      fnd_q    <= fnd_d;
      fw_q     <= fw_d;
      att_q    <= att_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = addr_q;
  assign hash_req   = req_q;
  assign hash_cand  = cand_q;
  assign state      = st_q;
  assign led        = led_code(st_q);
  assign found      = fnd_q;
  assign found_word = fw_q;
  assign attempts   = att_q;

endmodule

// File: tb/tb_crack_engine.sv
// Scoreboard bench for crack_engine: memory and hash-unit models,
// expected terminal results queued at start, checked by a monitor.
module tb_crack_engine;

  localparam int HW = 128;
  localparam int AW = 8;
  localparam logic [HW-1:0] K = 128'h5A5A_0F0F_3C3C_A5A5_1234_8765_F00D_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [HW-1:0] mem_rdata = '0;
  logic          hash_req;
  logic [HW-1:0] hash_cand;
  logic          hash_ack = 1'b0;
  logic [HW-1:0] hash_out = '0;
  logic [2:0]    state;
  logic [2:0]    led;
  logic          found;
  logic [HW-1:0] found_word;
  logic [31:0]   attempts;

  crack_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .hash_req  (hash_req),
    .hash_cand (hash_cand),
    .hash_ack  (hash_ack),
    .hash_out  (hash_out),
    .state     (state),
    .led       (led),
    .found     (found),
    .found_word(found_word),
    .attempts  (attempts)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] h(input logic [HW-1:0] x);
    return {x[HW-14:0], x[HW-1:HW-13]} ^ K;
  endfunction

  localparam logic [HW-1:0] W0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [HW-1:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [HW-1:0] W2 = 128'hCAFE_BABE_DEAD_BEEF_0BAD_F00D_1234_5678;

  logic [HW-1:0] mem [0:3];

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr[1:0]];
  end

  int            hdelay = 1;
  int            hcnt = 0;
  bit            hbusy = 1'b0;
  logic [HW-1:0] hlat = '0;

  // Once started, a request completes even if the DUT is reset meanwhile.
  always @(posedge clk) begin
    hash_ack <= 1'b0;
    if (!hbusy && hash_req && !hash_ack) begin
      hbusy = 1'b1;
      hcnt  = hdelay;
      hlat  = hash_cand;
    end
    if (hbusy) begin
      hcnt = hcnt - 1;
      if (hcnt == 0) begin
        hbusy = 1'b0;
        hash_ack <= 1'b1;
        hash_out <= h(hlat);
      end
    end
  end

  typedef struct {
    logic [2:0]    st;
    logic          fnd;
    logic [HW-1:0] fw;
    logic [31:0]   att;
    logic [2:0]    led;
    logic [31:0]   trace;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [HW-1:0] act,
                     input logic [HW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [2:0]    pst = 3'd0;
  logic [31:0]   trace = '0;
  logic          preq = 1'b0;
  logic [HW-1:0] pcand = '0;
  int            cand_bad = 0;
  int            saw3 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (hash_req && preq && hash_cand !== pcand) cand_bad++;
    if (state == 3'd3) saw3++;
    if (state != pst) begin
      if (state == 3'd0) trace = '0;
      else trace = {trace[28:0], state};
      if ((state == 3'd4 || state == 3'd5) && !(pst == 3'd4 || pst == 3'd5)) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: state %0d with nothing queued", state);
        end else begin
          e = q.pop_front();
          chk("state", state, e.st);
          chk("found", found, e.fnd);
          chk("found_word", found_word, e.fw);
          chk("attempts", attempts, e.att);
          chk("led", led, e.led);
          chk("state_trace", trace, e.trace);
        end
      end
    end
    pst   = state;
    preq  = hash_req;
    pcand = hash_cand;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (state < 3'd4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_terminal", (state >= 3'd4), 1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (state != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_state", state, s);
  endtask

  exp_t e_nomatch, e_brute7;

  initial begin
    mem[1] = W0;
    mem[2] = W1;
    mem[3] = W2;
    mem[0] = h(W2);

`ifdef CRACK_BRUTE_EN
    e_brute7  = '{3'd4, 1'b1, 128'd7, 32'd11, 3'b010, 32'o1234};
    e_nomatch = '{3'd5, 1'b0, '0, 32'd13, 3'b001, 32'o1235};
`else
    e_brute7  = '{3'd5, 1'b0, '0, 32'd3, 3'b001, 32'o125};
    e_nomatch = '{3'd5, 1'b0, '0, 32'd3, 3'b001, 32'o125};
`endif

    #1;
    chk("rst_state", state, 0);
    chk("rst_led", led, 3'b011);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hash_req", hash_req, 0);
    chk("rst_hash_cand", hash_cand, 0);
    chk("rst_found", found, 0);
    chk("rst_found_word", found_word, 0);
    chk("rst_attempts", attempts, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Dictionary hit on the last word, single-cycle hash unit.
    hdelay = 1;
    mem[0] = h(W2);
    q.push_back('{3'd4, 1'b1, W2, 32'd3, 3'b010, 32'o124});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("first_rd_en", mem_en, 1);
    chk("first_rd_addr", mem_addr, 0);
    chk("load_state", state, 1);
    start = 1'b0;
    wait_done();

    // Brute candidate 7 matches (or dictionary exhaustion -> FAIL).
    do_reset();
    mem[0] = h(128'd7);
    q.push_back(e_brute7);
    pulse_start();
    wait_done();

    // No match anywhere.
    do_reset();
    mem[0] = h(128'd100);
    q.push_back(e_nomatch);
    pulse_start();
    wait_done();

    // Reset while a request is outstanding; stale ack must be ignored.
    do_reset();
    hdelay = 4;
    mem[0] = h(W2);
    pulse_start();
    wait_state(3'd2);
    begin
      int n;
      n = 0;
      while (!hash_req && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("req_before_reset", hash_req, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("late_ack_state", state, 0);
    chk("late_ack_attempts", attempts, 0);
    chk("late_ack_found", found, 0);
    chk("late_ack_req", hash_req, 0);

    // Start glitches during DICT and SUCCESS with a slow hash unit.
    do_reset();
    hdelay = 5;
    mem[0] = h(W1);
    cand_bad = 0;
    q.push_back('{3'd4, 1'b1, W1, 32'd2, 3'b010, 32'o124});
    pulse_start();
    wait_state(3'd2);
    repeat (3) begin
      pulse_start();
      @(negedge clk);
    end
    wait_done();
    repeat (2) pulse_start();
    repeat (10) @(negedge clk);
    chk("success_held", state, 4);
    chk("success_word_held", found_word, W1);
    chk("success_att_held", attempts, 2);
    chk("cand_stable", cand_bad, 0);

`ifdef CRACK_BRUTE_EN
    chk("brute_seen", (saw3 > 0), 1);
`else
    chk("never_state3", saw3, 0);
`endif
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
